// File: rtl/freq_rom_voice_arbiter_if.sv
// Voice-side bundle for the frequency ROM arbiter: per-voice lookup requests
// and the shared period/ack return path.
interface freq_rom_voice_arbiter_if #(
  parameter int NVOICE    = 4,
  parameter int NBIT_ADX  = 7,
  parameter int NBIT_DATA = 16
);
  logic [NVOICE-1:0]          req;
  logic [NVOICE*NBIT_ADX-1:0] note_in;
  logic [NVOICE-1:0]          ack;
  logic [NBIT_DATA-1:0]       period_out;
  logic                       note_err;
  logic                       busy;

  modport master (output req, note_in, input ack, period_out, note_err, busy);
  modport slave  (input req, note_in, output ack, period_out, note_err, busy);
endinterface

// File: rtl/freq_rom_voice_arbiter.sv
// Round-robin sharing of one registered note->period ROM among NVOICE voices.
// One lookup per 4 cycles: IDLE (arbitrate) -> ISSUE -> CAPT -> DONE (ack).
module freq_rom_voice_arbiter #(
  parameter int NVOICE    = 4,
  parameter int NBIT_ADX  = 7,
  parameter int NBIT_DATA = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  freq_rom_voice_arbiter_if.slave bus,
  output logic                 rom_en,
  output logic [NBIT_ADX-1:0]  rom_addr,
  input  logic [NBIT_DATA-1:0] rom_data
);
  localparam int PW = (NVOICE > 1) ? $clog2(NVOICE) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, DONE} state_t;

  state_t                             state;
  logic [PW-1:0]                      ptr, gnt, win, gnt_nxt;
  logic [NVOICE-1:0]                  ack_q, gnt_dec;
  logic [NBIT_DATA-1:0]               period_q;
  logic                               err_q;
  logic [NVOICE-1:0][NBIT_ADX-1:0]    note_arr;

  assign note_arr       = bus.note_in;
  assign bus.ack        = ack_q;
  assign bus.period_out = period_q;
  assign bus.note_err   = err_q;
  assign bus.busy       = (state != IDLE);

  for (genvar i = 0; i < NVOICE; i++) begin : g_dec
    assign gnt_dec[i] = (gnt == PW'(i));
  end

  // Explicit wrap keeps the pointer legal when NVOICE is not a power of two.
  assign gnt_nxt = (gnt == PW'(NVOICE-1)) ? '0 : gnt + 1'b1;

  // Scan from farthest to nearest so the last hit is the first set bit at/after ptr.
  always_comb begin
    win = '0;
    for (int k = NVOICE-1; k >= 0; k--) begin
      logic [PW-1:0] idx;
      idx = PW'((int'(ptr) + k) % NVOICE);
      if (bus.req[idx]) win = idx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt      <= '0;
      ack_q    <= '0;
      period_q <= '0;
      err_q    <= 1'b0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            gnt      <= win;
            rom_addr <= note_arr[win];
            rom_en   <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          rom_en <= 1'b0;
          state  <= CAPT;
        end
        CAPT: begin
          period_q <= rom_data;
          err_q    <= (rom_data == '0);
          ack_q    <= gnt_dec;
          state    <= DONE;
        end
        DONE: begin
          ack_q <= '0;
          ptr   <= gnt_nxt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_freq_rom_voice_arbiter.sv
// Directed bench for freq_rom_voice_arbiter with a registered, en-gated ROM model.
module tb_freq_rom_voice_arbiter;
  logic        clk = 1'b0;
  logic        rstn;
  logic        rom_en;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc_cnt = 0;

  freq_rom_voice_arbiter_if #(.NVOICE(4), .NBIT_ADX(7), .NBIT_DATA(16)) vif ();

  freq_rom_voice_arbiter #(.NVOICE(4), .NBIT_ADX(7), .NBIT_DATA(16)) dut (
    .clk(clk), .rstn(rstn), .bus(vif.slave),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [15:0] rom_fn(input logic [6:0] n);
    if (n < 7'd12 || n > 7'd119) return 16'd0;
    case (n)
      7'd12:   return 16'd48537;
      7'd69:   return 16'd1804;
      7'd119:  return 16'd100;
      default: return 16'd1000 + 16'(n);
    endcase
  endfunction

  always @(posedge clk or negedge rstn)
    if (!rstn) rom_data <= '0;
    else if (rom_en) rom_data <= rom_fn(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ack(input int max_cyc, output int cyc, output logic [3:0] a,
                          output int en_cnt, output logic [6:0] en_addr);
    cyc = 0; a = '0; en_cnt = 0; en_addr = '0;
    while (cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
      if (rom_en) begin en_cnt++; en_addr = rom_addr; end
      if (vif.ack != 4'd0) begin a = vif.ack; break; end
    end
    chk("ack_seen", 32'(a != 4'd0), 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, 32'(vif.ack), 0);
    chk({tag, "_period"}, 32'(vif.period_out), 0);
    chk({tag, "_err"}, 32'(vif.note_err), 0);
    chk({tag, "_rom_en"}, 32'(rom_en), 0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
    chk({tag, "_busy"}, 32'(vif.busy), 0);
  endtask

  typedef struct {
    int          voice;
    logic [6:0]  note;
    logic [15:0] period;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          cyc, en_cnt;
    logic [3:0]  a;
    logic [6:0]  en_addr;
    logic [15:0] held_p;
    logic        held_e;
    int          t[5];
    logic [3:0]  exp_rr[5];

    vecs[0] = '{1, 7'd5,   16'd0,     1'b1};
    vecs[1] = '{3, 7'd125, 16'd0,     1'b1};
    vecs[2] = '{0, 7'd12,  16'd48537, 1'b0};
    vecs[3] = '{3, 7'd119, 16'd100,   1'b0};
    vecs[4] = '{1, 7'd11,  16'd0,     1'b1};
    vecs[5] = '{0, 7'd120, 16'd0,     1'b1};
    vecs[6] = '{3, 7'd60,  16'd1060,  1'b0};
    vecs[7] = '{2, 7'd69,  16'd1804,  1'b0};
    exp_rr  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rstn = 1'b0; vif.req = '0; vif.note_in = '0;
    repeat (2) @(negedge clk);
    chk_zero("por");
    rstn = 1'b1;

    // single-voice lookups, including out-of-range notes
    foreach (vecs[i]) begin
      @(negedge clk);
      vif.note_in[vecs[i].voice*7 +: 7] = vecs[i].note;
      vif.req = 4'(1 << vecs[i].voice);
      wait_ack(10, cyc, a, en_cnt, en_addr);
      vif.req = '0;
      chk($sformatf("v%0d_latency", i), 32'(cyc), 3);
      chk($sformatf("v%0d_ack", i), 32'(a), 32'(1 << vecs[i].voice));
      chk($sformatf("v%0d_period", i), 32'(vif.period_out), 32'(vecs[i].period));
      chk($sformatf("v%0d_err", i), 32'(vif.note_err), 32'(vecs[i].err));
      chk($sformatf("v%0d_en_cnt", i), 32'(en_cnt), 1);
      chk($sformatf("v%0d_addr", i), 32'(en_addr), 32'(vecs[i].note));
      held_p = vif.period_out; held_e = vif.note_err;
      @(posedge clk); #1;
      chk($sformatf("v%0d_ack_drop", i), 32'(vif.ack), 0);
      chk($sformatf("v%0d_idle", i), 32'(vif.busy), 0);
      chk($sformatf("v%0d_hold_p", i), 32'(vif.period_out), 32'(held_p));
      chk($sformatf("v%0d_hold_e", i), 32'(vif.note_err), 32'(held_e));
    end

    // reset in the middle of CAPT, then round-robin from voice 0
    @(negedge clk);
    for (int v = 0; v < 4; v++) vif.note_in[v*7 +: 7] = 7'(20 + v);
    vif.req = 4'b1111;
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b0; #1;
    chk_zero("mid_rst");
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_ack", 32'(vif.ack), 0);
    end
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_ack(12, cyc, a, en_cnt, en_addr);
      t[i] = cyc_cnt;
      chk($sformatf("rr%0d_ack", i), 32'(a), 32'(exp_rr[i]));
      chk($sformatf("rr%0d_period", i), 32'(vif.period_out), 32'(rom_fn(7'(20 + (i % 4)))));
      if (i > 0) chk($sformatf("rr%0d_spacing", i), 32'(t[i] - t[i-1]), 4);
    end
    vif.req = '0;
    @(posedge clk);

    // ptr now 1: voice 3 arriving during voice 0's CAPT must win over voice 0
    @(negedge clk);
    vif.note_in[0 +: 7] = 7'd30;
    vif.req = 4'b0001;
    @(posedge clk); @(posedge clk); #1;
    vif.note_in[21 +: 7] = 7'd40;
    vif.req = 4'b1001;
    wait_ack(10, cyc, a, en_cnt, en_addr);
    chk("cont_first_ack", 32'(a), 32'b0001);
    chk("cont_first_period", 32'(vif.period_out), 1030);
    wait_ack(10, cyc, a, en_cnt, en_addr);
    vif.req = '0;
    chk("cont_second_ack", 32'(a), 32'b1000);
    chk("cont_second_lat", 32'(cyc), 4);
    chk("cont_second_period", 32'(vif.period_out), 1040);
    @(posedge clk);

    // note_in change after the grant edge must not affect the lookup
    @(negedge clk);
    vif.note_in[0 +: 7] = 7'd12;
    vif.req = 4'b0001;
    @(posedge clk); #1;
    chk("stab_rom_en", 32'(rom_en), 1);
    chk("stab_rom_addr", 32'(rom_addr), 12);
    vif.note_in[0 +: 7] = 7'd119;
    wait_ack(10, cyc, a, en_cnt, en_addr);
    vif.req = '0;
    chk("stab_ack", 32'(a), 32'b0001);
    chk("stab_period", 32'(vif.period_out), 48537);
    chk("stab_err", 32'(vif.note_err), 0);
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
